// File: rtl/dct_quant_zigzag.sv
// Quantise/zigzag stage after the 8x8 DCT/IDCT: buffers blocks in a ping-pong RAM and streams them out over valid/ready.
// Optional ZQ_EOB_FLAG_EN adds per-block last-non-zero position and all-zero outputs.
module dct_quant_zigzag #(
  parameter int D_WIDTH = 13,
  parameter int Q_WIDTH = 12
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      dct_flag,
  input  logic                      dct_out_en,
  input  logic [5:0]                dct_out_idx,
  input  logic signed [D_WIDTH-1:0] dct_output,
  output logic                      zq_valid,
  input  logic                      zq_ready,
  output logic [5:0]                zq_idx,
  output logic signed [Q_WIDTH-1:0] zq_data,
  output logic                      zq_last,
  output logic                      zq_mode,
  output logic                      zq_overflow
`ifdef ZQ_EOB_FLAG_EN
  ,
  output logic [5:0]                zq_eob_idx,
  output logic [0:0]                zq_all_zero
`endif
);

  localparam int PW = D_WIDTH + 16;

  localparam int QLUMA [64] = '{
    16, 11, 10, 16, 24, 40, 51, 61,
    12, 12, 14, 19, 26, 58, 60, 55,
    14, 13, 16, 24, 40, 57, 69, 56,
    14, 17, 22, 29, 51, 87, 80, 62,
    18, 22, 37, 56, 68, 109, 103, 77,
    24, 35, 55, 64, 81, 104, 113, 92,
    49, 64, 78, 87, 103, 121, 120, 101,
    72, 92, 95, 98, 112, 100, 103, 99};

  // Raster index -> zigzag scan position.
  localparam int ZZ [64] = '{
     0,  1,  5,  6, 14, 15, 27, 28,
     2,  4,  7, 13, 16, 26, 29, 42,
     3,  8, 12, 17, 25, 30, 41, 43,
     9, 11, 18, 24, 31, 40, 44, 53,
    10, 19, 23, 32, 39, 45, 52, 54,
    20, 22, 33, 38, 46, 51, 55, 60,
    21, 34, 37, 47, 50, 56, 59, 61,
    35, 36, 48, 49, 57, 58, 62, 63};

  localparam logic [D_WIDTH:0]          QPOS_L = (D_WIDTH+1)'(2**(Q_WIDTH-1) - 1);
  localparam logic [D_WIDTH:0]          QNEG_L = (D_WIDTH+1)'(2**(Q_WIDTH-1));
  localparam logic [Q_WIDTH-1:0]        QMAX   = {1'b0, {(Q_WIDTH-1){1'b1}}};
  localparam logic [Q_WIDTH-1:0]        QMIN   = {1'b1, {(Q_WIDTH-1){1'b0}}};
  localparam logic signed [D_WIDTH-1:0] CMAX   = D_WIDTH'(2**(Q_WIDTH-1) - 1);
  localparam logic signed [D_WIDTH-1:0] CMIN   = D_WIDTH'(-(2**(Q_WIDTH-1)));

  function automatic logic [15:0] recip(input int q);
    return 16'((131072 + q) / (2 * q));
  endfunction

  logic [15:0] r_rom  [64];
  logic [5:0]  zz_rom [64];

  // Elaboration-time constants: each entry folds to a literal.
  generate
    for (genvar gi = 0; gi < 64; gi++) begin : g_rom
      assign r_rom[gi]  = recip(QLUMA[gi]);
      assign zz_rom[gi] = 6'(ZZ[gi]);
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_STREAM, S_RELEASE} rd_state_t;

  // Write side state
  logic               in_bank_q, in_bank_d;
  logic [5:0]         in_cnt_q, in_cnt_d;
  logic               in_mode_q, in_mode_d;
  logic               overflow_q, overflow_d;
  logic [1:0]         full_q, full_d;
  logic [1:0]         bank_mode_q, bank_mode_d;
  logic               s1_en_q, s1_en_d, s1_bank_q, s1_bank_d, s1_mode_q, s1_mode_d, s1_last_q, s1_last_d;
  logic [5:0]         s1_addr_q, s1_addr_d, s1_ridx_q, s1_ridx_d;
  logic [D_WIDTH-1:0] s1_c_q, s1_c_d;
  logic               s2_en_q, s2_en_d, s2_bank_q, s2_bank_d, s2_mode_q, s2_mode_d, s2_last_q, s2_last_d;
  logic [5:0]         s2_addr_q, s2_addr_d;
  logic [Q_WIDTH-1:0] s2_data_q, s2_data_d;
  logic               accept, blk_mode;
  logic [D_WIDTH-1:0] mag;
  logic               neg;
  logic [PW-1:0]      prod;
  logic [D_WIDTH:0]   qmag;

  // Read side state
  rd_state_t          state_q, state_d;
  logic               rd_bank_q, rd_bank_d;
  logic [5:0]         ptr_q, ptr_d;
  logic               rd_en, rel_bank;
  logic [6:0]         rd_addr;
  logic [Q_WIDTH-1:0] mem [128];
  logic [Q_WIDTH-1:0] rd_data_q;

`ifdef ZQ_EOB_FLAG_EN
  logic               s1_first_q, s1_first_d, s2_first_q, s2_first_d;
  logic [1:0][5:0]    eob_q, eob_d;
  logic [1:0]         nz_q, nz_d;
`endif

  always_comb begin
    // A bank being released this cycle is already free for the incoming coefficient.
    accept      = dct_out_en && (!full_q[in_bank_q] || (rel_bank && (rd_bank_q == in_bank_q)));
    blk_mode    = (in_cnt_q == 6'd0) ? dct_flag : in_mode_q;
    in_cnt_d    = in_cnt_q;
    in_bank_d   = in_bank_q;
    in_mode_d   = in_mode_q;
    overflow_d  = overflow_q;
    if (accept) begin
      in_cnt_d  = in_cnt_q + 6'd1;
      in_mode_d = blk_mode;
      if (in_cnt_q == 6'd63) in_bank_d = ~in_bank_q;
    end else if (dct_out_en) begin
      overflow_d = 1'b1;
    end
    s1_en_d   = accept;
    s1_bank_d = in_bank_q;
    s1_addr_d = blk_mode ? zz_rom[dct_out_idx] : dct_out_idx;
    s1_ridx_d = dct_out_idx;
    s1_mode_d = blk_mode;
    s1_last_d = (in_cnt_q == 6'd63);
    s1_c_d    = dct_output;
`ifdef ZQ_EOB_FLAG_EN
    s1_first_d = (in_cnt_q == 6'd0);
`endif
  end

  always_comb begin
    neg  = s1_c_q[D_WIDTH-1];
    mag  = neg ? (~s1_c_q + 1'b1) : s1_c_q;
    prod = PW'(mag) * PW'(r_rom[s1_ridx_q]);
    qmag = (D_WIDTH+1)'((prod + PW'(32'd32768)) >> 16);
    if (s1_mode_q) begin
      if (!neg) s2_data_d = (qmag > QPOS_L) ? QMAX : qmag[Q_WIDTH-1:0];
      else      s2_data_d = (qmag > QNEG_L) ? QMIN : (~qmag[Q_WIDTH-1:0] + 1'b1);
    end else begin
      if ($signed(s1_c_q) > CMAX)      s2_data_d = QMAX;
      else if ($signed(s1_c_q) < CMIN) s2_data_d = QMIN;
      else                             s2_data_d = s1_c_q[Q_WIDTH-1:0];
    end
    s2_en_d   = s1_en_q;
    s2_bank_d = s1_bank_q;
    s2_addr_d = s1_addr_q;
    s2_mode_d = s1_mode_q;
    s2_last_d = s1_last_q;
`ifdef ZQ_EOB_FLAG_EN
    s2_first_d = s1_first_q;
`endif
  end

  always_comb begin
    full_d      = full_q;
    bank_mode_d = bank_mode_q;
    if (rel_bank) full_d[rd_bank_q] = 1'b0;
    if (s2_en_q && s2_last_q) begin
      full_d[s2_bank_q]      = 1'b1;
      bank_mode_d[s2_bank_q] = s2_mode_q;
    end
`ifdef ZQ_EOB_FLAG_EN
    eob_d = eob_q;
    nz_d  = nz_q;
    if (s2_en_q) begin
      if (s2_first_q) begin
        eob_d[s2_bank_q] = (s2_data_q != '0) ? s2_addr_q : 6'd0;
        nz_d[s2_bank_q]  = (s2_data_q != '0);
      end else if (s2_data_q != '0) begin
        nz_d[s2_bank_q] = 1'b1;
        if (s2_addr_q > eob_q[s2_bank_q]) eob_d[s2_bank_q] = s2_addr_q;
      end
    end
`endif
  end

  // Read FSM: the RAM read address only advances on a transfer, so rd_data_q holds during stalls.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    rd_bank_d = rd_bank_q;
    rd_en     = 1'b0;
    rd_addr   = {rd_bank_q, ptr_q};
    rel_bank  = 1'b0;
    case (state_q)
      S_IDLE: begin
        ptr_d = 6'd0;
        if (full_q[rd_bank_q]) state_d = S_PRIME;
      end
      S_PRIME: begin
        rd_en   = 1'b1;
        rd_addr = {rd_bank_q, 6'd0};
        state_d = S_STREAM;
      end
      S_STREAM: begin
        if (zq_ready) begin
          if (ptr_q == 6'd63) begin
            state_d = S_RELEASE;
          end else begin
            ptr_d   = ptr_q + 6'd1;
            rd_en   = 1'b1;
            rd_addr = {rd_bank_q, ptr_q + 6'd1};
          end
        end
      end
      default: begin
        rel_bank  = 1'b1;
        rd_bank_d = ~rd_bank_q;
        ptr_d     = 6'd0;
        state_d   = full_q[~rd_bank_q] ? S_PRIME : S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      in_bank_q   <= 1'b0;
      in_cnt_q    <= '0;
      in_mode_q   <= 1'b0;
      overflow_q  <= 1'b0;
      full_q      <= '0;
      bank_mode_q <= '0;
      s1_en_q     <= 1'b0;
      s1_bank_q   <= 1'b0;
      s1_mode_q   <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_addr_q   <= '0;
      s1_ridx_q   <= '0;
      s1_c_q      <= '0;
      s2_en_q     <= 1'b0;
      s2_bank_q   <= 1'b0;
      s2_mode_q   <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_addr_q   <= '0;
      s2_data_q   <= '0;
      state_q     <= S_IDLE;
      rd_bank_q   <= 1'b0;
      ptr_q       <= '0;
`ifdef ZQ_EOB_FLAG_EN
      s1_first_q  <= 1'b0;
      s2_first_q  <= 1'b0;
      eob_q       <= '0;
      nz_q        <= '0;
`endif
    end else begin
      in_bank_q   <= in_bank_d;
      in_cnt_q    <= in_cnt_d;
      in_mode_q   <= in_mode_d;
      overflow_q  <= overflow_d;
      full_q      <= full_d;
      bank_mode_q <= bank_mode_d;
      s1_en_q     <= s1_en_d;
      s1_bank_q   <= s1_bank_d;
      s1_mode_q   <= s1_mode_d;
      s1_last_q   <= s1_last_d;
      s1_addr_q   <= s1_addr_d;
      s1_ridx_q   <= s1_ridx_d;
      s1_c_q      <= s1_c_d;
      s2_en_q     <= s2_en_d;
      s2_bank_q   <= s2_bank_d;
      s2_mode_q   <= s2_mode_d;
      s2_last_q   <= s2_last_d;
      s2_addr_q   <= s2_addr_d;
      s2_data_q   <= s2_data_d;
      state_q     <= state_d;
      rd_bank_q   <= rd_bank_d;
      ptr_q       <= ptr_d;
`ifdef ZQ_EOB_FLAG_EN
      s1_first_q  <= s1_first_d;
      s2_first_q  <= s2_first_d;
      eob_q       <= eob_d;
      nz_q        <= nz_d;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (s2_en_q) mem[{s2_bank_q, s2_addr_q}] <= s2_data_q;
    if (rd_en)   rd_data_q <= mem[rd_addr];
  end

  assign zq_valid    = (state_q == S_STREAM);
  assign zq_idx      = ptr_q;
  assign zq_data     = zq_valid ? $signed(rd_data_q) : '0;
  assign zq_last     = zq_valid && (ptr_q == 6'd63);
  assign zq_mode     = bank_mode_q[rd_bank_q];
  assign zq_overflow = overflow_q;
`ifdef ZQ_EOB_FLAG_EN
  assign zq_eob_idx  = eob_q[rd_bank_q];
  assign zq_all_zero = ~nz_q[rd_bank_q];
`endif

endmodule

// File: tb/tb_dct_quant_zigzag.sv
// Scoreboard bench for dct_quant_zigzag: a reference model queues expected words, a monitor checks every transfer.
module tb_dct_quant_zigzag;
  localparam int DW = 13;
  localparam int QW = 12;

  logic                 clock = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 dct_flag = 1'b0;
  logic                 dct_out_en = 1'b0;
  logic [5:0]           dct_out_idx = '0;
  logic signed [DW-1:0] dct_output = '0;
  logic                 zq_valid;
  logic                 zq_ready = 1'b0;
  logic [5:0]           zq_idx;
  logic signed [QW-1:0] zq_data;
  logic                 zq_last;
  logic                 zq_mode;
  logic                 zq_overflow;
`ifdef ZQ_EOB_FLAG_EN
  logic [5:0]           zq_eob_idx;
  logic [0:0]           zq_all_zero;
`endif

  dct_quant_zigzag #(.D_WIDTH(DW), .Q_WIDTH(QW)) dut (
    .clock(clock), .reset_n(reset_n), .dct_flag(dct_flag), .dct_out_en(dct_out_en),
    .dct_out_idx(dct_out_idx), .dct_output(dct_output), .zq_valid(zq_valid),
    .zq_ready(zq_ready), .zq_idx(zq_idx), .zq_data(zq_data), .zq_last(zq_last),
    .zq_mode(zq_mode), .zq_overflow(zq_overflow)
`ifdef ZQ_EOB_FLAG_EN
    , .zq_eob_idx(zq_eob_idx), .zq_all_zero(zq_all_zero)
`endif
  );

  always #5 clock = ~clock;

  int QTAB [64] = '{
    16, 11, 10, 16, 24, 40, 51, 61,
    12, 12, 14, 19, 26, 58, 60, 55,
    14, 13, 16, 24, 40, 57, 69, 56,
    14, 17, 22, 29, 51, 87, 80, 62,
    18, 22, 37, 56, 68, 109, 103, 77,
    24, 35, 55, 64, 81, 104, 113, 92,
    49, 64, 78, 87, 103, 121, 120, 101,
    72, 92, 95, 98, 112, 100, 103, 99};

  typedef struct { int idx; int data; bit last; bit mode; int eob; bit az; } exp_t;
  exp_t exp_q[$];

  int zz [64];
  int blk [64];
  int order [64];
  int total = 0;
  int bad = 0;
  int words_out = 0;
  int ready_mode = 1;   // 0 = hold low, 1 = hold high, 2 = random
  bit stall_prev = 0;
  int hold_idx, hold_data;

  task automatic check_val(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  function automatic int clampq(input longint v);
    if (v > 2047) return 2047;
    if (v < -2048) return -2048;
    return int'(v);
  endfunction

  function automatic int quant(input int c, input int r);
    int     rc;
    longint mag, t;
    rc  = $rtoi(65536.0 / QTAB[r] + 0.5);
    mag = (c < 0) ? -c : c;
    t   = (mag * rc + 32768) / 65536;
    return clampq((c < 0) ? -t : t);
  endfunction

  task automatic push_block(input bit mode);
    int out [64];
    int eob;
    bit az;
    for (int r = 0; r < 64; r++) begin
      if (mode) out[zz[r]] = quant(blk[r], r);
      else      out[r]     = clampq(blk[r]);
    end
    eob = 0;
    az  = 1;
    for (int p = 0; p < 64; p++) if (out[p] != 0) begin eob = p; az = 0; end
    for (int p = 0; p < 64; p++) begin
      exp_t e;
      e.idx = p; e.data = out[p]; e.last = (p == 63); e.mode = mode; e.eob = eob; e.az = az;
      exp_q.push_back(e);
    end
  endtask

  task automatic do_reset(input string tag);
    dct_out_en = 1'b0;
    reset_n    = 1'b0;
    #1;
    check_val({tag, "_rst_valid"}, int'(zq_valid), 0);
    check_val({tag, "_rst_idx"}, int'(zq_idx), 0);
    check_val({tag, "_rst_data"}, int'(zq_data), 0);
    check_val({tag, "_rst_last"}, int'(zq_last), 0);
    check_val({tag, "_rst_mode"}, int'(zq_mode), 0);
    check_val({tag, "_rst_ovf"}, int'(zq_overflow), 0);
    exp_q.delete();
    repeat (3) @(posedge clock);
    #2 reset_n = 1'b1;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 64; i++) blk[i] = int'($urandom_range(0, 8191)) - 4096;
  endtask

  task automatic fill_zero();
    for (int i = 0; i < 64; i++) blk[i] = 0;
  endtask

  // Sends the 64 coefficients of blk in shuffled raster order; abort_at >= 0 resets mid-block.
  task automatic send_block(input bit mode, input int abort_at, input bit keep, input bit gaps);
    for (int i = 0; i < 64; i++) order[i] = i;
    for (int i = 63; i > 0; i--) begin
      int j, t;
      j = int'($urandom_range(0, i));
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
    for (int i = 0; i < 64; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(posedge clock); #1;
        dct_out_en = 1'b0;
        dct_flag   = 1'($urandom_range(0, 1));
      end
      @(posedge clock); #1;
      if (i == abort_at) begin
        do_reset("mid_block");
        return;
      end
      dct_out_en  = 1'b1;
      dct_out_idx = 6'(order[i]);
      dct_output  = DW'(blk[order[i]]);
      dct_flag    = (i == 0) ? mode : 1'($urandom_range(0, 1));
    end
    @(posedge clock); #1;
    dct_out_en = 1'b0;
    if (keep) push_block(mode);
  endtask

  task automatic wait_drain(input string tag, input int maxc);
    int n = 0;
    while (exp_q.size() != 0 && n < maxc) begin
      @(posedge clock);
      n++;
    end
    check_val({tag, "_drain_left"}, exp_q.size(), 0);
    exp_q.delete();
    repeat (4) @(posedge clock);
  endtask

  task automatic wait_words(input int target, input int maxc);
    int n = 0;
    while (words_out < target && n < maxc) begin
      @(posedge clock);
      n++;
    end
    total++;
    if (words_out < target) begin
      bad++;
      $display("FAIL wait_words: got %0d expected >= %0d", words_out, target);
    end
  endtask

  always @(posedge clock) begin
    #1;
    case (ready_mode)
      0:       zq_ready = 1'b0;
      1:       zq_ready = 1'b1;
      default: zq_ready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clock) begin
    if (reset_n && zq_valid) begin
      if (stall_prev) begin
        check_val("stall_idx", int'(zq_idx), hold_idx);
        check_val("stall_data", int'(zq_data), hold_data);
      end
      if (zq_ready) begin
        stall_prev = 0;
        words_out++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word: got idx %0d data %0d expected no output", zq_idx, zq_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check_val("xfer_idx", int'(zq_idx), e.idx);
          check_val("xfer_data", int'(zq_data), e.data);
          check_val("xfer_last", int'(zq_last), int'(e.last));
          check_val("xfer_mode", int'(zq_mode), int'(e.mode));
`ifdef ZQ_EOB_FLAG_EN
          check_val("xfer_eob", int'(zq_eob_idx), e.eob);
          check_val("xfer_allzero", int'(zq_all_zero), int'(e.az));
`endif
        end
      end else begin
        stall_prev = 1;
        hold_idx   = int'(zq_idx);
        hold_data  = int'(zq_data);
      end
    end else begin
      stall_prev = 0;
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int p, base;
    p = 0;
    for (int s = 0; s < 15; s++) begin
      if (s % 2 == 0) begin
        for (int r = (s < 7 ? s : 7); r >= (s > 7 ? s - 7 : 0); r--) begin zz[r*8 + (s - r)] = p; p++; end
      end else begin
        for (int r = (s > 7 ? s - 7 : 0); r <= (s < 7 ? s : 7); r++) begin zz[r*8 + (s - r)] = p; p++; end
      end
    end

    ready_mode = 1;
    do_reset("por");

    // Single DC coefficient in DCT mode
    fill_zero(); blk[0] = 1000;
    send_block(1, -1, 1, 0);
    wait_drain("dc", 400);

    // Sparse DCT block with small and negative values
    fill_zero(); blk[1] = -25; blk[8] = 6; blk[63] = -1000; blk[19] = 500;
    send_block(1, -1, 1, 1);
    wait_drain("sparse", 400);

    // IDCT pass-through ramp with both saturation limits
    for (int k = 0; k < 64; k++) blk[k] = k - 32;
    blk[5] = 4095; blk[6] = -4096;
    send_block(0, -1, 1, 0);
    wait_drain("idct", 400);

    // All-zero DCT block
    fill_zero();
    send_block(1, -1, 1, 0);
    wait_drain("zero", 400);

    // Three blocks with the consumer stalled: third block is dropped
    ready_mode = 0;
    repeat (2) @(posedge clock);
    fill_random(); send_block(1, -1, 1, 0);
    fill_random(); send_block(0, -1, 1, 0);
    fill_random(); send_block(1, -1, 0, 0);
    repeat (5) @(posedge clock);
    check_val("overflow_set", int'(zq_overflow), 1);
    base = words_out;
    ready_mode = 1;
    wait_drain("ovf", 600);
    repeat (10) @(posedge clock);
    check_val("ovf_word_count", words_out - base, 128);
    check_val("overflow_sticky", int'(zq_overflow), 1);
    do_reset("post_ovf");

    // Four random blocks under random backpressure, paced so no bank overflows
    ready_mode = 2;
    base = words_out;
    for (int b = 0; b < 4; b++) begin
      if (b >= 2) begin
        wait_words(base + (b - 1) * 64, 2000);
        repeat (4) @(posedge clock);
      end
      fill_random();
      send_block(1'($urandom_range(0, 1)), -1, 1, 1);
    end
    wait_drain("rand", 3000);
    check_val("rand_no_overflow", int'(zq_overflow), 0);

    // Reset while coefficient 30 is being delivered, then a clean block
    ready_mode = 1;
    fill_random(); send_block(1, 30, 0, 0);
    fill_random(); send_block(1, -1, 1, 0);
    wait_drain("after_blk_rst", 400);

    // Reset while a block is streaming out, then a clean block
    ready_mode = 2;
    base = words_out;
    fill_random(); send_block(0, -1, 1, 0);
    wait_words(base + 20, 1000);
    #2;
    reset_n = 1'b0;
    #1;
    check_val("stream_rst_valid", int'(zq_valid), 0);
    exp_q.delete();
    repeat (3) @(posedge clock);
    #2 reset_n = 1'b1;
    fill_random(); send_block(1, -1, 1, 1);
    wait_drain("after_stream_rst", 1000);

    check_val("final_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
